uart_rx_word: RTL and testbench

- 8N1 UART receiver for the clock_test UART path.
- Samples the serial line at mid-bit using a clock-divided bit timer.
- Presents each received byte as a one-cycle pulse.
- Packs every 4 consecutive good bytes into a 32-bit word with a valid/ready handshake. The word is the receive-side counterpart of the 32-bit word the transmitter serialises.

---
 rtl/uart_rx_word.sv | 151 +++++++++++++++
 tb/tb_uart_rx_word.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_word.sv
// 8N1 UART receiver with mid-bit sampling.
// Received bytes are packed four at a time into a 32-bit word that is handed off with valid/ready.
module uart_rx_word #(
  parameter int FREQ = 12000000,
  parameter int BAUD = 9600
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        rxd,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic [31:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy
);

  localparam int LIM  = FREQ / BAUD;
  localparam int HALF = LIM / 2;
  localparam int CW   = $clog2(LIM);
  localparam logic [CW-1:0] LIM_M1  = CW'(LIM - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] T_ONE   = CW'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t        state;
  logic [CW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [31:0]   word_sr;
  logic [1:0]    byte_idx;
  logic          rx_m, rx_s, rx_prev;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= rxd;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      word_sr    <= '0;
      byte_idx   <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      word_data  <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      // A load on the 4th byte later in this block overrides this clear
      if (word_valid && word_ready)
        word_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            state <= START;
            timer <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (timer == HALF_M1) begin
            if (!rx_s) begin
              state   <= DATA;
              timer   <= '0;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer + T_ONE;
          end
        end
        DATA: begin
          if (timer == LIM_M1) begin
            shreg   <= {rx_s, shreg[7:1]};
            timer   <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7)
              state <= STOP;
          end else begin
            timer <= timer + T_ONE;
          end
        end
        STOP: begin
          if (timer == LIM_M1) begin
            timer <= '0;
            if (rx_s) begin
              byte_data  <= shreg;
              byte_valid <= 1'b1;
              word_sr    <= {shreg, word_sr[31:8]};
              byte_idx   <= byte_idx + 2'd1;
              if (byte_idx == 2'd3) begin
                if (!word_valid || word_ready) begin
                  word_data  <= {shreg, word_sr[31:8]};
                  word_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            timer <= timer + T_ONE;
          end
        end
        WAIT_IDLE: begin
          // Line must stay high for a full bit time; any low restarts the count
          if (!rx_s) begin
            timer <= '0;
          end else if (timer == LIM_M1) begin
            timer <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            timer <= timer + T_ONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word: a default-rate instance for latency and false-start checks,
// and a fast instance (16 clocks per bit) for packing, overrun, framing and reset cases.
module tb_uart_rx_word;

  localparam int SF   = 160;
  localparam int SB   = 10;
  localparam int LIM  = SF / SB;
  localparam int DLIM = 12000000 / 9600;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        rxd = 1'b1;
  logic        word_ready = 1'b0;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic [31:0] word_data;
  logic        word_valid;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  logic        d_rxd = 1'b1;
  logic        d_ready = 1'b0;
  logic [7:0]  d_byte_data;
  logic        d_byte_valid;
  logic [31:0] d_word_data;
  logic        d_word_valid;
  logic        d_frame_err;
  logic        d_overrun;
  logic        d_busy;

  always #5 clk = ~clk;

  uart_rx_word #(.FREQ(SF), .BAUD(SB)) dut (
    .clk(clk), .nrst(nrst), .rxd(rxd),
    .byte_data(byte_data), .byte_valid(byte_valid),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  uart_rx_word #(.FREQ(12000000), .BAUD(9600)) dut_def (
    .clk(clk), .nrst(nrst), .rxd(d_rxd),
    .byte_data(d_byte_data), .byte_valid(d_byte_valid),
    .word_data(d_word_data), .word_valid(d_word_valid), .word_ready(d_ready),
    .frame_err(d_frame_err), .overrun(d_overrun), .busy(d_busy)
  );

  int total = 0;
  int bad = 0;
  int bv_cnt = 0, fe_cnt = 0, ov_cnt = 0;
  int d_bv_cnt = 0, d_fe_cnt = 0, d_ov_cnt = 0;

  always @(negedge clk) begin
    if (byte_valid)   bv_cnt++;
    if (frame_err)    fe_cnt++;
    if (overrun)      ov_cnt++;
    if (d_byte_valid) d_bv_cnt++;
    if (d_frame_err)  d_fe_cnt++;
    if (d_overrun)    d_ov_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    int          low_bits;
    logic        accept;
    logic [7:0]  exp_bd;
    int          exp_bv;
    int          exp_fe;
    int          exp_ov;
    logic        exp_wv;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t tbl [21];

  task automatic run_vec(input vec_t v, input int idx);
    int bv0, fe0, ov0;
    if (v.accept) begin
      @(negedge clk);
      chk($sformatf("v%0d_acc_pre", idx), {31'd0, word_valid}, 32'd1);
      word_ready = 1'b1;
      @(negedge clk);
      word_ready = 1'b0;
      chk($sformatf("v%0d_acc_drop", idx), {31'd0, word_valid}, 32'd0);
    end
    bv0 = bv_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    rxd = 1'b0;
    repeat (LIM) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = v.data[i];
      repeat (LIM) @(negedge clk);
    end
    rxd = v.stop;
    repeat (LIM) @(negedge clk);
    if (v.low_bits > 0) begin
      rxd = 1'b0;
      repeat (v.low_bits * LIM) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (v.stop ? LIM : 2 * LIM) @(negedge clk);
    chk($sformatf("v%0d_bv", idx), bv_cnt - bv0, v.exp_bv);
    chk($sformatf("v%0d_fe", idx), fe_cnt - fe0, v.exp_fe);
    chk($sformatf("v%0d_ov", idx), ov_cnt - ov0, v.exp_ov);
    chk($sformatf("v%0d_bd", idx), {24'd0, byte_data}, {24'd0, v.exp_bd});
    chk($sformatf("v%0d_wv", idx), {31'd0, word_valid}, {31'd0, v.exp_wv});
    chk($sformatf("v%0d_wd", idx), word_data, v.exp_wd);
  endtask

  initial begin
    int lat;
    int b;
    int bv0, fe0;
    logic [9:0] fr;

    //          data  stop low acc  bd    bv fe ov wv    wd
    tbl[0]  = '{8'h53, 1'b1, 0, 1'b0, 8'h53, 1, 0, 0, 1'b0, 32'h00000000};
    tbl[1]  = '{8'h6E, 1'b1, 0, 1'b0, 8'h6E, 1, 0, 0, 1'b0, 32'h00000000};
    tbl[2]  = '{8'h61, 1'b1, 0, 1'b0, 8'h61, 1, 0, 0, 1'b0, 32'h00000000};
    tbl[3]  = '{8'h70, 1'b1, 0, 1'b0, 8'h70, 1, 0, 0, 1'b1, 32'h70616E53};
    tbl[4]  = '{8'h01, 1'b1, 0, 1'b1, 8'h01, 1, 0, 0, 1'b0, 32'h70616E53};
    tbl[5]  = '{8'h02, 1'b1, 0, 1'b0, 8'h02, 1, 0, 0, 1'b0, 32'h70616E53};
    tbl[6]  = '{8'h03, 1'b1, 0, 1'b0, 8'h03, 1, 0, 0, 1'b0, 32'h70616E53};
    tbl[7]  = '{8'h04, 1'b1, 0, 1'b0, 8'h04, 1, 0, 0, 1'b1, 32'h04030201};
    tbl[8]  = '{8'h05, 1'b1, 0, 1'b0, 8'h05, 1, 0, 0, 1'b1, 32'h04030201};
    tbl[9]  = '{8'h06, 1'b1, 0, 1'b0, 8'h06, 1, 0, 0, 1'b1, 32'h04030201};
    tbl[10] = '{8'h07, 1'b1, 0, 1'b0, 8'h07, 1, 0, 0, 1'b1, 32'h04030201};
    tbl[11] = '{8'h08, 1'b1, 0, 1'b0, 8'h08, 1, 0, 1, 1'b1, 32'h04030201};
    tbl[12] = '{8'h41, 1'b0, 3, 1'b0, 8'h08, 0, 1, 0, 1'b1, 32'h04030201};
    tbl[13] = '{8'h42, 1'b1, 0, 1'b0, 8'h42, 1, 0, 0, 1'b1, 32'h04030201};
    tbl[14] = '{8'h43, 1'b1, 0, 1'b1, 8'h43, 1, 0, 0, 1'b0, 32'h04030201};
    tbl[15] = '{8'h44, 1'b1, 0, 1'b0, 8'h44, 1, 0, 0, 1'b0, 32'h04030201};
    tbl[16] = '{8'h45, 1'b1, 0, 1'b0, 8'h45, 1, 0, 0, 1'b1, 32'h45444342};
    tbl[17] = '{8'h9A, 1'b1, 0, 1'b0, 8'h9A, 1, 0, 0, 1'b0, 32'h00000000};
    tbl[18] = '{8'hB1, 1'b1, 0, 1'b0, 8'hB1, 1, 0, 0, 1'b0, 32'h00000000};
    tbl[19] = '{8'hB2, 1'b1, 0, 1'b0, 8'hB2, 1, 0, 0, 1'b0, 32'h00000000};
    tbl[20] = '{8'hB3, 1'b1, 0, 1'b0, 8'hB3, 1, 0, 0, 1'b1, 32'hB3B2B19A};

    repeat (4) @(negedge clk);
    chk("rst_bd",   {24'd0, byte_data}, 32'd0);
    chk("rst_wd",   word_data, 32'd0);
    chk("rst_flags", {27'd0, byte_valid, word_valid, frame_err, overrun, busy}, 32'd0);
    chk("rst_d_wd", d_word_data, 32'd0);
    nrst = 1'b1;
    repeat (4) @(negedge clk);

    // Default-rate byte 0x53, latency counted from the falling edge of rxd
    fr = {1'b1, 8'h53, 1'b0};
    lat = 0;
    d_rxd = 1'b0;
    for (int c = 1; c <= 11 * DLIM; c++) begin
      @(negedge clk);
      if (d_byte_valid && lat == 0) lat = c;
      b = c / DLIM;
      d_rxd = (b < 10) ? fr[b] : 1'b1;
    end
    total++;
    if (lat < 11877 || lat > 11879) begin
      bad++;
      $display("FAIL d_latency: got %0d expected 11878 +/-1", lat);
    end
    chk("d_bv_cnt", d_bv_cnt, 32'd1);
    chk("d_bd", {24'd0, d_byte_data}, 32'h53);
    chk("d_fe_cnt", d_fe_cnt, 32'd0);
    chk("d_ov_cnt", d_ov_cnt, 32'd0);
    chk("d_wv", {31'd0, d_word_valid}, 32'd0);

    // False start: 100 low cycles, well short of the half-bit sample point
    bv0 = d_bv_cnt; fe0 = d_fe_cnt;
    d_rxd = 1'b0;
    repeat (50) @(negedge clk);
    chk("d_glitch_busy_hi", {31'd0, d_busy}, 32'd1);
    repeat (50) @(negedge clk);
    d_rxd = 1'b1;
    repeat (600) @(negedge clk);
    chk("d_glitch_busy_lo", {31'd0, d_busy}, 32'd0);
    chk("d_glitch_bv", d_bv_cnt - bv0, 32'd0);
    chk("d_glitch_fe", d_fe_cnt - fe0, 32'd0);

    for (int i = 0; i <= 16; i++) run_vec(tbl[i], i);

    // Reset in the middle of the data bits of a frame
    rxd = 1'b0;
    repeat (3 * LIM) @(negedge clk);
    chk("mid_busy_pre", {31'd0, busy}, 32'd1);
    nrst = 1'b0;
    @(negedge clk);
    chk("mid_rst_wd", word_data, 32'd0);
    chk("mid_rst_bd", {24'd0, byte_data}, 32'd0);
    chk("mid_rst_flags", {27'd0, byte_valid, word_valid, frame_err, overrun, busy}, 32'd0);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    nrst = 1'b1;
    repeat (2 * LIM) @(negedge clk);
    chk("mid_idle_busy", {31'd0, busy}, 32'd0);

    for (int i = 17; i <= 20; i++) run_vec(tbl[i], i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
